video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Next-generation test-pattern source: one block containing the raster timing counters and a multi-mode pattern engine.
- Replaces the fixed 1080p, 8-bit, colour-bar-only generator.
- Timing, colour depth and sync polarity are parameters. The pattern is selected at run time and changes only on frame boundaries.
- Sits at the head of the video pipeline and drives the downstream scaler, overlay and HDMI/LVDS transmitter.

Parameters:
COLOR_DEPTH, 8, bits per channel (4..12)
X_BITS, 12, width of horizontal counter and act_x
Y_BITS, 12, width of vertical counter and act_y
H_TOTAL, 2200, pixels per line
H_SYNC, 44, hsync width in pixels
H_BP, 148, horizontal back porch
H_ACT, 1920, active pixels per line
V_TOTAL, 1125, lines per frame
V_SYNC, 5, vsync width in lines
V_BP, 36, vertical back porch
V_ACT, 1080, active lines per frame
HS_POL, 1, 1 = hs_out active-high, 0 = active-low
VS_POL, 1, same rule for vs_out
CHK_LOG2, 6, log2 of the checkerboard square size in pixels
RAMP_SHIFT, 3, right shift applied to act_x for the gray ramp

Ports:
pix_clk  input  1  pixel clock; all logic runs on its rising edge
rst_out  input  1  synchronous reset, active-high
mode_in  input  3  pattern select; sampled only at frame start
solid_rgb  input  3*COLOR_DEPTH  {R,G,B} colour for solid mode; sampled with mode_in
vs_out  output  1  vertical sync, polarity set by VS_POL
hs_out  output  1  horizontal sync, polarity set by HS_POL
de_out  output  1  active-video enable
r_out  output  COLOR_DEPTH  red
g_out  output  COLOR_DEPTH  green
b_out  output  COLOR_DEPTH  blue
act_x  output  X_BITS  active pixel column, aligned with de_out
act_y  output  Y_BITS  active line, aligned with de_out
frame_cnt  output  16  completed-frame counter, wraps at 0xFFFF to 0
mode_cur  output  3  mode currently being displayed

Behaviour:
Reset (rst_out=1 at a clock edge):
- h_cnt, v_cnt and frame_cnt clear to 0; mode_cur clears to 0.
- de_out, r_out, g_out, b_out, act_x and act_y clear to 0.
- hs_out and vs_out go to their inactive level (~HS_POL, ~VS_POL).
- Reset asserted mid-frame aborts the frame. After release the first output is frame start (h=0, v=0) on the next cycle.

Counters:
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- frame_cnt increments when both counters wrap together.

Decode, from the counter values:
- hs active when h_cnt < H_SYNC.
- vs active when v_cnt < V_SYNC; vs changes at h_cnt = 0 only.
- de when H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACT.
- Active coordinates: ax = h_cnt-(H_SYNC+H_BP), ay = v_cnt-(V_SYNC+V_BP). act_x and act_y hold 0 when de is low.

Mode latch:
- At h_cnt=0 and v_cnt=0, mode_cur <= mode_in and the internal solid register <= solid_rgb.
- A mode_in change mid-frame has no effect until the next frame start.

Latency:
- All outputs are registered: 1 cycle from the counter state to the pins.
- hs, vs, de, act_x, act_y and RGB are mutually aligned, with zero skew between them.

Patterns (RGB forced to 0 whenever de is 0). MAX = 2^COLOR_DEPTH-1.
- Mode 0, colour bars:
  - bar = ax / (H_ACT/8), a constant divisor computed at elaboration; clamped to 7.
  - Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black. Each channel is MAX or 0.
- Mode 1, gray ramp: R=G=B = ax >> RAMP_SHIFT, saturated at MAX.
- Mode 2, checkerboard: ax[CHK_LOG2] XOR ay[CHK_LOG2]; 1 gives all channels MAX, 0 gives all channels 0.
- Mode 3, solid: latched solid value.
- Mode 4, moving bar:
  - White 8-pixel-wide vertical bar on black. The bar covers columns p..p+7, where p = (frame_cnt*4) mod H_ACT; pixels with ax >= H_ACT are not drawn.
  - The bar advances once per frame.
- Modes 5-7: all channels 0 (reserved).

Width rules:
- Constant comparisons use X_BITS/Y_BITS-wide unsigned arithmetic.
- Parameter legality: H_SYNC+H_BP+H_ACT < H_TOTAL, V_SYNC+V_BP+V_ACT < V_TOTAL, and H_TOTAL < 2^X_BITS, V_TOTAL < 2^Y_BITS. An elaboration check halts when these are violated.

Test Plan:
1. Small timing (H_TOTAL=20, H_SYNC=2, H_BP=3, H_ACT=8, V_TOTAL=10, V_SYNC=1, V_BP=2, V_ACT=4), reset 3 cycles, release -> exactly 8 de cycles per active line, 4 active lines per frame; hs high for 2 cycles every 20; vs high for 20 cycles every 200; frame_cnt=1 after 200 cycles.
2. Mode 0, COLOR_DEPTH=8, H_ACT=8 -> pixel k carries bar k: pixel 0 = FF/FF/FF, pixel 1 = FF/FF/00, pixel 5 = FF/00/00, pixel 7 = 00/00/00.
3. Mode 1, RAMP_SHIFT=0, COLOR_DEPTH=4, H_ACT=32 -> R=G=B equals ax for ax 0..15 and saturates at 0xF for ax 16..31.
4. mode_in changed from 0 to 3 (solid_rgb=12_34_56) mid-frame -> remainder of the frame stays colour bars; the next frame is solid 12/34/56; mode_cur updates on the cycle after frame start.
5. rst_out asserted for 1 cycle mid-active-line -> the next cycle shows de_out=0, RGB=0 and inactive syncs; counting then restarts from h=0, v=0 and frame_cnt is 0.
6. HS_POL=0, VS_POL=0, mode 2, CHK_LOG2=1 -> syncs are active-low and idle high in reset; checker pixel (2,0) = MAX, (0,0) = 0, (2,2) = 0.

Source files
------------

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//
// Purpose:
//     Parameterised raster timing generator plus multi-mode test-pattern
//     engine. It is the head of the video pipeline and feeds the scaler,
//     overlay and HDMI/LVDS transmitter.
//
//     Counter state (h, v) is decoded and pattern pixels are computed
//     combinationally. Every output is then registered once, so syncs,
//     de, active coordinates and RGB all leave on the same clock edge.
//     The pattern mode and the solid colour are latched only at frame start.
//
// Ports:
//     pix_clk    in   pixel clock, rising edge
//     rst_out    in   synchronous reset, active-high
//     mode_in    in   pattern select (0 bars, 1 ramp, 2 checker, 3 solid,
//                     4 moving bar, 5-7 black)
//     solid_rgb  in   {R,G,B} colour used by solid mode
//     vs_out     out  vertical sync, active level VS_POL
//     hs_out     out  horizontal sync, active level HS_POL
//     de_out     out  active-video enable
//     r_out      out  red channel
//     g_out      out  green channel
//     b_out      out  blue channel
//     act_x      out  active column, 0 outside active video
//     act_y      out  active line, 0 outside active video
//     frame_cnt  out  completed-frame counter, wraps at 0xFFFF
//     mode_cur   out  pattern mode being displayed this frame
// ---------------------------------------------------------------------------
module video_pattern_gen #(
    parameter int COLOR_DEPTH = 8,
    parameter int X_BITS      = 12,
    parameter int Y_BITS      = 12,
    parameter int H_TOTAL     = 2200,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int H_ACT       = 1920,
    parameter int V_TOTAL     = 1125,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter int V_ACT       = 1080,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int CHK_LOG2    = 6,
    parameter int RAMP_SHIFT  = 3
) (
    input  logic                     pix_clk,
    input  logic                     rst_out,
    input  logic [2:0]               mode_in,
    input  logic [3*COLOR_DEPTH-1:0] solid_rgb,
    output logic                     vs_out,
    output logic                     hs_out,
    output logic                     de_out,
    output logic [COLOR_DEPTH-1:0]   r_out,
    output logic [COLOR_DEPTH-1:0]   g_out,
    output logic [COLOR_DEPTH-1:0]   b_out,
    output logic [X_BITS-1:0]        act_x,
    output logic [Y_BITS-1:0]        act_y,
    output logic [15:0]              frame_cnt,
    output logic [2:0]               mode_cur
);

    // Timing landmarks, all expressed at counter width.
    localparam logic [X_BITS-1:0] H_LAST     = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_SYNC_END = X_BITS'(H_SYNC);
    localparam logic [X_BITS-1:0] H_DE_START = X_BITS'(H_SYNC + H_BP);
    localparam logic [X_BITS-1:0] H_DE_END   = X_BITS'(H_SYNC + H_BP + H_ACT);
    localparam logic [Y_BITS-1:0] V_LAST     = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_SYNC_END = Y_BITS'(V_SYNC);
    localparam logic [Y_BITS-1:0] V_DE_START = Y_BITS'(V_SYNC + V_BP);
    localparam logic [Y_BITS-1:0] V_DE_END   = Y_BITS'(V_SYNC + V_BP + V_ACT);

    localparam int                   BAR_W   = H_ACT / 8;
    localparam int                   MAX_INT = (1 << COLOR_DEPTH) - 1;
    localparam logic [COLOR_DEPTH-1:0] MAXV  = {COLOR_DEPTH{1'b1}};
    localparam logic                 HS_ON   = (HS_POL != 0);
    localparam logic                 VS_ON   = (VS_POL != 0);
    localparam int                   WIDE    = X_BITS + COLOR_DEPTH;

    // Reject timing sets that cannot be represented or would break the
    // bar divisor, the checker bit select or the colour-depth range.
    if (COLOR_DEPTH < 4 || COLOR_DEPTH > 12 ||
        H_SYNC + H_BP + H_ACT >= H_TOTAL ||
        V_SYNC + V_BP + V_ACT >= V_TOTAL ||
        H_TOTAL >= (1 << X_BITS) || V_TOTAL >= (1 << Y_BITS) ||
        H_ACT < 8 || X_BITS < 3 ||
        CHK_LOG2 >= X_BITS || CHK_LOG2 >= Y_BITS) begin : g_paramCheck
        $fatal(1, "video_pattern_gen: illegal parameter set");
    end

    logic [X_BITS-1:0]        r_hCnt;
    logic [Y_BITS-1:0]        r_vCnt;
    logic [15:0]              r_frameCnt;
    logic [2:0]               r_modeCur;
    logic [3*COLOR_DEPTH-1:0] r_solid;
    logic [X_BITS-1:0]        r_barPos;

    logic                     r_vs;
    logic                     r_hs;
    logic                     r_de;
    logic [COLOR_DEPTH-1:0]   r_r;
    logic [COLOR_DEPTH-1:0]   r_g;
    logic [COLOR_DEPTH-1:0]   r_b;
    logic [X_BITS-1:0]        r_actX;
    logic [Y_BITS-1:0]        r_actY;

    logic                     w_hLast;
    logic                     w_vLast;
    logic                     w_frameStart;
    logic                     w_hsAct;
    logic                     w_vsAct;
    logic                     w_de;
    logic [X_BITS-1:0]        w_ax;
    logic [Y_BITS-1:0]        w_ay;
    logic [X_BITS:0]          w_barNext;
    logic [X_BITS-1:0]        w_barQuot;
    logic [2:0]               w_barIdx;
    logic [X_BITS-1:0]        w_ramp;
    logic [COLOR_DEPTH-1:0]   w_rampSat;
    logic [X_BITS:0]          w_movEnd;
    logic                     w_inMovBar;
    logic                     w_chkOn;
    logic [COLOR_DEPTH-1:0]   w_r;
    logic [COLOR_DEPTH-1:0]   w_g;
    logic [COLOR_DEPTH-1:0]   w_b;

    // Raster decode from the current counter state. vs follows v_cnt, which
    // only moves when h wraps, so it naturally changes at h = 0.
    always_comb begin
        w_hLast      = (r_hCnt == H_LAST);
        w_vLast      = (r_vCnt == V_LAST);
        w_frameStart = (r_hCnt == '0) && (r_vCnt == '0);
        w_hsAct      = (r_hCnt < H_SYNC_END);
        w_vsAct      = (r_vCnt < V_SYNC_END);
        w_de         = (r_hCnt >= H_DE_START) && (r_hCnt < H_DE_END) &&
                       (r_vCnt >= V_DE_START) && (r_vCnt < V_DE_END);
        w_ax         = w_de ? (r_hCnt - H_DE_START) : '0;
        w_ay         = w_de ? (r_vCnt - V_DE_START) : '0;
    end

    // Moving-bar origin is kept as a running (frame*4) mod H_ACT so no
    // multiplier or divider is needed; it snaps back to 0 when frame_cnt wraps.
    always_comb begin
        w_barNext = {1'b0, r_barPos} + (X_BITS+1)'(4);
        if (w_barNext >= (X_BITS+1)'(H_ACT)) begin
            w_barNext = w_barNext - (X_BITS+1)'(H_ACT);
        end
    end

    // Per-pixel pattern generation. The bar divisor is an elaboration-time
    // constant; columns past the last full bar clamp to bar 7 (black).
    always_comb begin
        w_barQuot  = w_ax / X_BITS'(BAR_W);
        w_barIdx   = (w_barQuot > X_BITS'(7)) ? 3'd7 : w_barQuot[2:0];
        w_ramp     = w_ax >> RAMP_SHIFT;
        w_rampSat  = (WIDE'(w_ramp) > WIDE'(MAX_INT)) ? MAXV : COLOR_DEPTH'(w_ramp);
        w_movEnd   = {1'b0, r_barPos} + (X_BITS+1)'(8);
        w_inMovBar = ({1'b0, w_ax} >= {1'b0, r_barPos}) && ({1'b0, w_ax} < w_movEnd);
        w_chkOn    = w_ax[CHK_LOG2] ^ w_ay[CHK_LOG2];
        w_r        = '0;
        w_g        = '0;
        w_b        = '0;
        if (w_de) begin
            case (r_modeCur)
                3'd0: begin
                    // Bar index bits map directly onto the classic bar order.
                    w_r = {COLOR_DEPTH{~w_barIdx[1]}};
                    w_g = {COLOR_DEPTH{~w_barIdx[2]}};
                    w_b = {COLOR_DEPTH{~w_barIdx[0]}};
                end
                3'd1: begin
                    w_r = w_rampSat;
                    w_g = w_rampSat;
                    w_b = w_rampSat;
                end
                3'd2: begin
                    w_r = {COLOR_DEPTH{w_chkOn}};
                    w_g = {COLOR_DEPTH{w_chkOn}};
                    w_b = {COLOR_DEPTH{w_chkOn}};
                end
                3'd3: begin
                    w_r = r_solid[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
                    w_g = r_solid[2*COLOR_DEPTH-1:COLOR_DEPTH];
                    w_b = r_solid[COLOR_DEPTH-1:0];
                end
                3'd4: begin
                    w_r = {COLOR_DEPTH{w_inMovBar}};
                    w_g = {COLOR_DEPTH{w_inMovBar}};
                    w_b = {COLOR_DEPTH{w_inMovBar}};
                end
                default: begin
                    w_r = '0;
                    w_g = '0;
                    w_b = '0;
                end
            endcase
        end
    end

    // Counters, frame-start latching and the single output register stage.
    // Reset aborts the current frame; the first edge after release then
    // processes h = 0, v = 0 as a normal frame start.
    always_ff @(posedge pix_clk) begin
        if (rst_out) begin
            r_hCnt     <= '0;
            r_vCnt     <= '0;
            r_frameCnt <= '0;
            r_modeCur  <= '0;
            r_solid    <= '0;
            r_barPos   <= '0;
            r_vs       <= ~VS_ON;
            r_hs       <= ~HS_ON;
            r_de       <= 1'b0;
            r_r        <= '0;
            r_g        <= '0;
            r_b        <= '0;
            r_actX     <= '0;
            r_actY     <= '0;
        end else begin
            r_hCnt <= w_hLast ? '0 : (r_hCnt + 1'b1);
            if (w_hLast) begin
                r_vCnt <= w_vLast ? '0 : (r_vCnt + 1'b1);
            end
            if (w_hLast && w_vLast) begin
                r_frameCnt <= r_frameCnt + 16'd1;
                r_barPos   <= (r_frameCnt == 16'hFFFF) ? '0 : X_BITS'(w_barNext);
            end
            if (w_frameStart) begin
                r_modeCur <= mode_in;
                r_solid   <= solid_rgb;
            end
            r_vs   <= w_vsAct ? VS_ON : ~VS_ON;
            r_hs   <= w_hsAct ? HS_ON : ~HS_ON;
            r_de   <= w_de;
            r_r    <= w_r;
            r_g    <= w_g;
            r_b    <= w_b;
            r_actX <= w_ax;
            r_actY <= w_ay;
        end
    end

    assign vs_out    = r_vs;
    assign hs_out    = r_hs;
    assign de_out    = r_de;
    assign r_out     = r_r;
    assign g_out     = r_g;
    assign b_out     = r_b;
    assign act_x     = r_actX;
    assign act_y     = r_actY;
    assign frame_cnt = r_frameCnt;
    assign mode_cur  = r_modeCur;

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
//
// Purpose:
//     Self-checking bench for video_pattern_gen using a small raster
//     (48x10 total, 32x4 active, 4-bit colour, active-low hsync,
//     active-high vsync). Expected outputs come from a reference model that
//     derives everything from the absolute cycle count since reset release.
// ---------------------------------------------------------------------------
module tb_video_pattern_gen;

    localparam int CD       = 4;
    localparam int XB       = 8;
    localparam int YB       = 8;
    localparam int HT       = 48;
    localparam int H_SYNC_W = 2;
    localparam int HBP      = 3;
    localparam int HA       = 32;
    localparam int VT       = 10;
    localparam int V_SYNC_W = 1;
    localparam int VBP      = 2;
    localparam int VA       = 4;
    localparam int HSP      = 0;
    localparam int VSP      = 1;
    localparam int CHK      = 1;
    localparam int RS       = 0;
    localparam int FRAME    = HT * VT;
    localparam int MAXV     = (1 << CD) - 1;

    typedef struct packed {
        logic          vs;
        logic          hs;
        logic          de;
        logic [CD-1:0] r;
        logic [CD-1:0] g;
        logic [CD-1:0] b;
        logic [XB-1:0] ax;
        logic [YB-1:0] ay;
        logic [15:0]   frame;
        logic [2:0]    mode;
    } outs_t;

    logic            pix_clk;
    logic            rst_out;
    logic [2:0]      mode_in;
    logic [3*CD-1:0] solid_rgb;
    logic            vs_out;
    logic            hs_out;
    logic            de_out;
    logic [CD-1:0]   r_out;
    logic [CD-1:0]   g_out;
    logic [CD-1:0]   b_out;
    logic [XB-1:0]   act_x;
    logic [YB-1:0]   act_y;
    logic [15:0]     frame_cnt;
    logic [2:0]      mode_cur;

    int              vectors;
    int              miscompares;
    int              t;
    logic [2:0]      modelMode;
    logic [3*CD-1:0] modelSolid;
    outs_t           expOut;
    outs_t           obsOut;

    video_pattern_gen #(
        .COLOR_DEPTH(CD), .X_BITS(XB), .Y_BITS(YB),
        .H_TOTAL(HT), .H_SYNC(H_SYNC_W), .H_BP(HBP), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(V_SYNC_W), .V_BP(VBP), .V_ACT(VA),
        .HS_POL(HSP), .VS_POL(VSP), .CHK_LOG2(CHK), .RAMP_SHIFT(RS)
    ) dut (
        .pix_clk(pix_clk), .rst_out(rst_out), .mode_in(mode_in),
        .solid_rgb(solid_rgb), .vs_out(vs_out), .hs_out(hs_out),
        .de_out(de_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .act_x(act_x), .act_y(act_y), .frame_cnt(frame_cnt),
        .mode_cur(mode_cur)
    );

    // Free-running pixel clock.
    initial pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    // Reference model: outputs expected after the edge that processes raster
    // position st (cycles since reset release).
    function automatic outs_t modelOutputs(input int st);
        outs_t      o;
        int         h;
        int         v;
        int         f;
        int         ax;
        int         ay;
        int         bar;
        int         lvl;
        int         p;
        bit         on;
        logic [2:0] bars [8];
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        o = '0;
        h = st % HT;
        v = (st / HT) % VT;
        f = (st / FRAME) % 65536;
        o.hs    = ((h < H_SYNC_W) == (HSP != 0));
        o.vs    = ((v < V_SYNC_W) == (VSP != 0));
        o.frame = 16'((st + 1) / FRAME);
        o.mode  = modelMode;
        if (h >= H_SYNC_W + HBP && h < H_SYNC_W + HBP + HA &&
            v >= V_SYNC_W + VBP && v < V_SYNC_W + VBP + VA) begin
            ax   = h - (H_SYNC_W + HBP);
            ay   = v - (V_SYNC_W + VBP);
            o.de = 1'b1;
            o.ax = XB'(ax);
            o.ay = YB'(ay);
            case (modelMode)
                3'd0: begin
                    bar = ax / (HA / 8);
                    if (bar > 7) bar = 7;
                    o.r = bars[bar][2] ? CD'(MAXV) : '0;
                    o.g = bars[bar][1] ? CD'(MAXV) : '0;
                    o.b = bars[bar][0] ? CD'(MAXV) : '0;
                end
                3'd1: begin
                    lvl = ax >> RS;
                    if (lvl > MAXV) lvl = MAXV;
                    o.r = CD'(lvl);
                    o.g = CD'(lvl);
                    o.b = CD'(lvl);
                end
                3'd2: begin
                    on  = (((ax >> CHK) ^ (ay >> CHK)) & 1) != 0;
                    o.r = on ? CD'(MAXV) : '0;
                    o.g = on ? CD'(MAXV) : '0;
                    o.b = on ? CD'(MAXV) : '0;
                end
                3'd3: {o.r, o.g, o.b} = modelSolid;
                3'd4: begin
                    p   = (f * 4) % HA;
                    on  = (ax >= p) && (ax < p + 8);
                    o.r = on ? CD'(MAXV) : '0;
                    o.g = on ? CD'(MAXV) : '0;
                    o.b = on ? CD'(MAXV) : '0;
                end
                default: begin
                    o.r = '0;
                    o.g = '0;
                    o.b = '0;
                end
            endcase
        end
        return o;
    endfunction

    function automatic outs_t dutOutputs();
        return {vs_out, hs_out, de_out, r_out, g_out, b_out,
                act_x, act_y, frame_cnt, mode_cur};
    endfunction

    // One clock edge: mirror the frame-start latch in the model, clock, then
    // compute what the DUT should show #1 after the edge.
    task automatic applyStimulus(input bit rst);
        rst_out = rst;
        if (!rst && (t % FRAME) == 0) begin
            modelMode  = mode_in;
            modelSolid = solid_rgb;
        end
        @(posedge pix_clk);
        #1;
        if (rst) begin
            modelMode  = 3'd0;
            expOut     = '0;
            expOut.hs  = (HSP == 0);
            expOut.vs  = (VSP == 0);
            t          = 0;
        end else begin
            expOut = modelOutputs(t);
            t      = t + 1;
        end
        obsOut = dutOutputs();
    endtask

    task automatic test_reset();
        mode_in   = 3'd0;
        solid_rgb = '0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL reset cyc%0d got %h want %h", i, obsOut, expOut);
            end
        end
        vectors++;
        if (hs_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_hs_idle got %b want 1", hs_out);
        end
    endtask

    task automatic test_timing();
        int deCnt;
        int hsCnt;
        int vsCnt;
        deCnt   = 0;
        hsCnt   = 0;
        vsCnt   = 0;
        mode_in = 3'd0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0);
            deCnt += int'(de_out);
            hsCnt += int'(hs_out == 1'b0);
            vsCnt += int'(vs_out == 1'b1);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL timing t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
        end
        vectors += 4;
        if (deCnt !== HA * VA) begin
            miscompares++;
            $display("[TB] FAIL de_count got %0d want %0d", deCnt, HA * VA);
        end
        if (hsCnt !== H_SYNC_W * VT) begin
            miscompares++;
            $display("[TB] FAIL hs_count got %0d want %0d", hsCnt, H_SYNC_W * VT);
        end
        if (vsCnt !== V_SYNC_W * HT) begin
            miscompares++;
            $display("[TB] FAIL vs_count got %0d want %0d", vsCnt, V_SYNC_W * HT);
        end
        if (frame_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL frame_after_one got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_color_bars();
        mode_in = 3'd0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL bars t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
            if (de_out && act_x == XB'(20)) begin
                vectors++;
                if ({r_out, g_out, b_out} !== 12'hF00) begin
                    miscompares++;
                    $display("[TB] FAIL bar5_red got %h want f00", {r_out, g_out, b_out});
                end
            end
        end
    endtask

    task automatic test_gray_ramp();
        mode_in = 3'd1;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL ramp t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
            if (de_out && (act_x == XB'(7) || act_x == XB'(20))) begin
                vectors++;
                if (r_out !== ((act_x == XB'(7)) ? 4'h7 : 4'hF)) begin
                    miscompares++;
                    $display("[TB] FAIL ramp_point x=%0d got %h", act_x, r_out);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        mode_in = 3'd0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME / 2) begin
                mode_in   = 3'd3;
                solid_rgb = 12'($urandom);
            end
            applyStimulus(1'b0);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL mode_switch t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
        end
    endtask

    task automatic test_checker();
        mode_in = 3'd2;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL checker t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
            if (de_out && act_x == XB'(2) && (act_y == YB'(0) || act_y == YB'(2))) begin
                vectors++;
                if (r_out !== ((act_y == YB'(0)) ? 4'hF : 4'h0)) begin
                    miscompares++;
                    $display("[TB] FAIL checker_px y=%0d got %h", act_y, r_out);
                end
            end
        end
    endtask

    task automatic test_moving_bar();
        mode_in = 3'd4;
        for (int i = 0; i < 4 * FRAME; i++) begin
            applyStimulus(1'b0);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL moving_bar t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
        end
    endtask

    task automatic test_random_modes();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(49) == 0) begin
                mode_in   = 3'($urandom_range(7));
                solid_rgb = 12'($urandom);
            end
            applyStimulus(1'b0);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL random t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        mode_in = 3'd0;
        guard   = 0;
        while ((t % FRAME) != 4 * HT + 10 && guard < 2 * FRAME) begin
            applyStimulus(1'b0);
            guard++;
        end
        applyStimulus(1'b1);
        vectors++;
        if (obsOut !== expOut) begin
            miscompares++;
            $display("[TB] FAIL mid_reset got %h want %h", obsOut, expOut);
        end
        for (int i = 0; i < FRAME + 5; i++) begin
            applyStimulus(1'b0);
            vectors++;
            if (obsOut !== expOut) begin
                miscompares++;
                $display("[TB] FAIL after_reset t=%0d got %h want %h", t - 1, obsOut, expOut);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        modelMode   = 3'd0;
        modelSolid  = '0;
        rst_out     = 1'b1;
        mode_in     = 3'd0;
        solid_rgb   = '0;
        test_reset();
        test_timing();
        test_color_bars();
        test_gray_ramp();
        test_mode_switch();
        test_checker();
        test_moving_bar();
        test_random_modes();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
